// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Write-side front end for a small register file. Accepts
//               writeback requests from the ALU and load paths over
//               valid/ready handshakes. Requests are buffered in an in-order
//               queue, and one request per cycle is drained onto the register
//               file's single registered write port. A per-register pending
//               mask is exported so that decode can stall dependent reads.
// Ports       : clk, rst              - clock, async active-high reset
//               alu_valid/ready/addr/data - ALU writeback request
//               mem_valid/ready/addr/data - load writeback request (priority)
//               wr_hold               - freezes the queue head while high
//               wr_en/wr_addr/wr_data - registered register-file write port
//               busy                  - per-register write-pending mask
//               count                 - number of queued entries
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      wr_hold,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [(1<<ADDR_W)-1:0]    busy,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  // Queue storage and bookkeeping
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // Registered write port
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Handshake and queue control
  logic              full;
  logic              push_mem;
  logic              push_alu;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [DEPTH-1:0]  slot_valid;
  logic [NREG-1:0]   busy_vec;

  // Readiness looks only at the registered count: a pop in the same cycle
  // does not open a slot, which keeps ready free of any path from wr_hold.
  assign full      = (count_q == C_FULL);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign push_mem  = mem_valid && !full;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_mem || push_alu;
  assign push_addr = push_mem ? mem_addr : alu_addr;
  assign push_data = push_mem ? mem_data : alu_data;

  assign pop       = (count_q != '0) && !wr_hold;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + C_CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - C_CNT_ONE;
    end
  end

  // When nothing drains, the address/data outputs keep their last values.
  always_comb begin
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = addr_mem_q[rptr_q];
      wr_data_d = data_mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (push) begin
        addr_mem_q[wptr_q] <= push_addr;
        data_mem_q[wptr_q] <= push_data;
        wptr_q             <= wptr_q + C_PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + C_PTR_ONE;
      end
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // A slot holds a live entry when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] slot_off;
    assign slot_off       = PTR_W'(gi) - rptr_q;
    assign slot_valid[gi] = (CNT_W'(slot_off) < count_q);
  end

  // Duplicates simply OR together, so a bit stays set until the last write
  // to that register has left the write port.
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        busy_vec[addr_mem_q[i]] = 1'b1;
      end
    end
    if (wr_en_q) begin
      busy_vec[wr_addr_q] = 1'b1;
    end
  end

  assign busy    = busy_vec;
  assign count   = count_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Self-checking bench for reg_writeback. A transaction-level
//               queue model predicts readiness, the write port, the busy
//               mask and the occupancy each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 2;
  localparam int NREG   = 4;
  localparam int CNT_W  = 2;

  typedef logic [ADDR_W+DATA_W-1:0] ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wr_hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  count;

  reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_hold(wr_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model state: pending requests in acceptance order plus the
  // write currently presented to the register file.
  ent_t              mq[$];
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                last_acc_alu, last_acc_mem;
  ent_t              wlog[$];

  int tests = 0;
  int fails = 0;

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b;
    b = '0;
    foreach (mq[i]) b[mq[i][ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
    if (m_en) b[m_addr] = 1'b1;
    return b;
  endfunction

  // {alu_ready, mem_ready, wr_en, wr_addr, wr_data, busy, count}
  function automatic logic [14:0] exp_v();
    bit full;
    full = (mq.size() >= DEPTH);
    return {!full && !mem_valid, !full, m_en, m_addr, m_data, m_busy(), CNT_W'(mq.size())};
  endfunction

  function automatic logic [14:0] obs_v();
    return {alu_ready, mem_ready, wr_en, wr_addr, wr_data, busy, count};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_addr = '0; m_data = '0;
    last_acc_alu = 1'b0; last_acc_mem = 1'b0;
  endtask

  // Applies the acceptance/drain rules to the model for one rising edge.
  task automatic model_edge();
    bit full;
    ent_t e;
    full = (mq.size() >= DEPTH);
    last_acc_mem = mem_valid && !full;
    last_acc_alu = alu_valid && !full && !mem_valid;
    if (mq.size() > 0 && !wr_hold) begin
      e = mq.pop_front();
      m_en = 1'b1;
      {m_addr, m_data} = e;
    end else begin
      m_en = 1'b0;
    end
    if (last_acc_mem)      mq.push_back({mem_addr, mem_data});
    else if (last_acc_alu) mq.push_back({alu_addr, alu_data});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    wr_hold = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (obs_v() !== 15'b1_1_0_00_0000_0000_00) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", obs_v(), 15'b1_1_0_00_0000_0000_00);
    end
    tick();
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 4'hA;
    @(negedge clk);
    tests++;
    if (alu_ready !== 1'b1) begin
      fails++; $display("FAIL single_ready: got %b expected 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({wr_en, busy[2]} !== 2'b01) begin
      fails++; $display("FAIL single_queued: wr_en/busy2 got %b expected 01", {wr_en, busy[2]});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({wr_en, wr_addr, wr_data, busy[2]} !== {1'b1, 2'd2, 4'hA, 1'b1}) begin
      fails++; $display("FAIL single_write: got %b expected %b",
                        {wr_en, wr_addr, wr_data, busy[2]}, {1'b1, 2'd2, 4'hA, 1'b1});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({wr_en, busy} !== 5'b0_0000) begin
      fails++; $display("FAIL single_retire: wr_en/busy got %b expected 00000", {wr_en, busy});
    end
    tick();
  endtask

  task automatic test_priority();
    wlog.delete();
    mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 4'd3;
    alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 4'd5;
    @(negedge clk);
    tests++;
    if ({mem_ready, alu_ready} !== 2'b10) begin
      fails++; $display("FAIL prio_ready: mem/alu got %b expected 10", {mem_ready, alu_ready});
    end
    tick();
    mem_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (obs_v() !== exp_v()) begin
        fails++; $display("FAIL prio_cycle%0d: got %h expected %h", c, obs_v(), exp_v());
      end
      if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
      tick();
      if (last_acc_alu) alu_valid = 1'b0;
    end
    tests++;
    if (wlog.size() != 2 || wlog[0] !== {2'd1, 4'd3} || wlog[1] !== {2'd0, 4'd5}) begin
      fails++; $display("FAIL prio_order: got %0d writes first %h expected (1,3) then (0,5)",
                        wlog.size(), (wlog.size() > 0) ? wlog[0] : ent_t'(0));
    end
  endtask

  task automatic test_full();
    logic [ADDR_W-1:0] a_tab [3];
    logic [DATA_W-1:0] d_tab [3];
    int idx;
    a_tab = '{2'd3, 2'd3, 2'd2};
    d_tab = '{4'd1, 4'd2, 4'd7};
    wlog.delete();
    idx = 0;
    wr_hold = 1'b1;
    alu_valid = 1'b1; alu_addr = a_tab[0]; alu_data = d_tab[0];
    for (int c = 0; c < 12; c++) begin
      if (c == 4) wr_hold = 1'b0;
      @(negedge clk);
      tests++;
      if (obs_v() !== exp_v()) begin
        fails++; $display("FAIL full_cycle%0d: got %h expected %h", c, obs_v(), exp_v());
      end
      if (c == 3) begin
        tests++;
        if ({count, alu_ready, mem_ready, busy[3]} !== {2'd2, 1'b0, 1'b0, 1'b1}) begin
          fails++; $display("FAIL full_state: count/ready/busy3 got %b expected 10001",
                            {count, alu_ready, mem_ready, busy[3]});
        end
      end
      if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
      tick();
      if (last_acc_alu) begin
        idx++;
        if (idx < 3) begin
          alu_addr = a_tab[idx]; alu_data = d_tab[idx];
        end else begin
          alu_valid = 1'b0;
        end
      end
    end
    tests++;
    if (wlog.size() != 3 || wlog[0] !== {2'd3, 4'd1} || wlog[1] !== {2'd3, 4'd2} ||
        wlog[2] !== {2'd2, 4'd7}) begin
      fails++; $display("FAIL full_order: got %0d writes expected (3,1),(3,2),(2,7)", wlog.size());
    end
  endtask

  task automatic test_stream();
    int first_cyc, last_cyc, nw;
    bit rdy_ok;
    wlog.delete();
    nw = 0; first_cyc = -1; last_cyc = -1; rdy_ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 8);
      alu_addr  = ADDR_W'(c % 4);
      alu_data  = DATA_W'(c);
      @(negedge clk);
      tests++;
      if (obs_v() !== exp_v()) begin
        fails++; $display("FAIL stream_cycle%0d: got %h expected %h", c, obs_v(), exp_v());
      end
      if (c < 8 && alu_ready !== 1'b1) rdy_ok = 1'b0;
      if (wr_en === 1'b1) begin
        wlog.push_back({wr_addr, wr_data});
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nw++;
      end
      tick();
    end
    tests++;
    if (!rdy_ok || nw != 8 || (last_cyc - first_cyc) != 7) begin
      fails++; $display("FAIL stream_rate: ready_ok %0d writes %0d span %0d expected 1 8 7",
                        rdy_ok, nw, last_cyc - first_cyc);
    end
    for (int i = 0; i < wlog.size(); i++) begin
      tests++;
      if (wlog[i][DATA_W-1:0] !== DATA_W'(i)) begin
        fails++; $display("FAIL stream_data%0d: got %h expected %h", i, wlog[i][DATA_W-1:0], i);
      end
    end
  endtask

  task automatic test_hold_mid();
    int idx;
    bit saw_full;
    wlog.delete();
    idx = 0; saw_full = 1'b0;
    alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 4'd0;
    for (int c = 0; c < 20; c++) begin
      wr_hold = (c >= 3 && c < 6);
      @(negedge clk);
      tests++;
      if (obs_v() !== exp_v()) begin
        fails++; $display("FAIL hold_cycle%0d: got %h expected %h", c, obs_v(), exp_v());
      end
      if (count === 2'd2 && alu_ready === 1'b0) saw_full = 1'b1;
      if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
      tick();
      if (last_acc_alu) begin
        idx++;
        if (idx < 10) begin
          alu_addr = ADDR_W'(idx % 4); alu_data = DATA_W'(idx);
        end else begin
          alu_valid = 1'b0;
        end
      end
    end
    wr_hold = 1'b0;
    tests++;
    if (!saw_full || wlog.size() != 10) begin
      fails++; $display("FAIL hold_fill: saw_full %0d writes %0d expected 1 10", saw_full, wlog.size());
    end
    for (int i = 0; i < wlog.size(); i++) begin
      tests++;
      if (wlog[i][DATA_W-1:0] !== DATA_W'(i)) begin
        fails++; $display("FAIL hold_data%0d: got %h expected %h", i, wlog[i][DATA_W-1:0], i);
      end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 300; c++) begin
      wr_hold = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      tests++;
      if (obs_v() !== exp_v()) begin
        fails++; $display("FAIL rand_cycle%0d: got %h expected %h", c, obs_v(), exp_v());
      end
      tick();
      // Producers keep an unaccepted request stable until it is taken.
      if (!alu_valid || last_acc_alu) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = ADDR_W'($urandom);
        alu_data  = DATA_W'($urandom);
      end
      if (!mem_valid || last_acc_mem) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_addr  = ADDR_W'($urandom);
        mem_data  = DATA_W'($urandom);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    repeat (3) tick();
    wr_hold = 1'b1;
    alu_valid = 1'b1; alu_addr = 2'd1; alu_data = 4'h6;
    tick();
    alu_addr = 2'd3; alu_data = 4'h9;
    tick();
    alu_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({wr_en, count, busy} !== 7'b0) begin
      fails++; $display("FAIL reset_mid: wr_en/count/busy got %b expected 0000000", {wr_en, count, busy});
    end
    model_reset();
    wr_hold = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (wr_en !== 1'b0 || obs_v() !== exp_v()) begin
        fails++; $display("FAIL reset_after%0d: got %h expected %h", c, obs_v(), exp_v());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_stream();
    test_hold_mid();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
